// File: rtl/rv32_isa_pkg.sv
// ---------------------------------------------------------------------------
// rv32_isa -- shared definitions for the instruction fetch stage.
//   NOP            : canonical RV32I no-op (addi x0,x0,0), used for bubbles
//   fetch_state_e  : fetch controller states
//   fetch_word_t   : one instruction as presented to decode {pc, pc4, ins}
//   word_align()   : clears the two low address bits
// ---------------------------------------------------------------------------
package rv32_isa;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DROP  = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] ins;
   } fetch_word_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if -- control, memory and decode-side signals of the fetch stage.
//   iEn, iStall, iPCS_EXT, iPC_EXT : enable, decode back-pressure, redirect
//   oIMemReq, oIMemAddr            : instruction memory request / address
//   iIMemAck, iIMemData            : memory response strobe / data
//   oPC, oPC4, oINS, oValid        : instruction presented to decode
//   fetch_state                    : current controller state (observability)
//
// Handshakes: on the memory side oIMemReq is a request that stays high with
// oIMemAddr stable until a cycle with iIMemAck=1, which transfers iIMemData in
// that same cycle. On the decode side oValid qualifies oPC/oPC4/oINS, and
// iStall=1 means decode does not take them, so they are held unchanged.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
   import rv32_isa::*;

   logic         iEn;
   logic         iStall;
   logic         iPCS_EXT;
   logic [31:0]  iPC_EXT;
   logic         oIMemReq;
   logic [31:0]  oIMemAddr;
   logic         iIMemAck;
   logic [31:0]  iIMemData;
   logic [31:0]  oPC;
   logic [31:0]  oPC4;
   logic [31:0]  oINS;
   logic         oValid;
   fetch_state_e fetch_state;

   modport slave (
      input  iEn, iStall, iPCS_EXT, iPC_EXT, iIMemAck, iIMemData,
      output oIMemReq, oIMemAddr, oPC, oPC4, oINS, oValid, fetch_state
   );

   modport master (
      output iEn, iStall, iPCS_EXT, iPC_EXT, iIMemAck, iIMemData,
      input  oIMemReq, oIMemAddr, oPC, oPC4, oINS, oValid, fetch_state
   );

endinterface

// File: rtl/fetch_stage_skid_buffer.sv
// ---------------------------------------------------------------------------
// skid_buffer -- one-entry holding register for an instruction that arrived
// while decode was stalled.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture din and mark the entry valid
//   clear      : drop the entry (wins over load)
//   din / dout : 96-bit {pc, pc4, ins}
//   valid      : entry holds a captured instruction
// ---------------------------------------------------------------------------
module skid_buffer
   import rv32_isa::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        clear,
   input  fetch_word_t din,
   output fetch_word_t dout,
   output logic        valid
);

   fetch_word_t word_q;
   logic        valid_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q  <= '0;
         valid_q <= 1'b0;
      end else if (clear) begin
         valid_q <= 1'b0;
      end else if (load) begin
         word_q  <= din;
         valid_q <= 1'b1;
      end
   end

   assign dout  = word_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction fetch with decode stall, skid capture and
// redirect handling.
//   RESET_VECTOR : first fetch address after reset
//   iClk         : clock, all state changes on the rising edge
//   nRst         : synchronous active-low reset
//   bus          : fetch_stage_if.slave (memory, decode and control signals)
// ---------------------------------------------------------------------------
module fetch_stage
   import rv32_isa::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
)
(
   input  logic         iClk,
   input  logic         nRst,
   fetch_stage_if.slave bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  target_q, target_d;
   fetch_word_t  out_q, out_d;
   logic         valid_q, valid_d;

   logic         skid_load;
   logic         skid_clear;
   fetch_word_t  skid_word;
   logic         skid_valid;

   logic         req;
   fetch_word_t  fetched;

   // A request is outstanding in S_FETCH and in S_DROP (the latter waits for
   // the abandoned access to complete so exactly one ack is thrown away).
   assign req     = (state_q == S_FETCH) || (state_q == S_DROP);
   assign fetched = '{pc: fetch_pc_q, pc4: fetch_pc_q + 32'd4, ins: bus.iIMemData};

   skid_buffer u_skid (
      .clk   (iClk),
      .rst_n (nRst),
      .load  (skid_load),
      .clear (skid_clear),
      .din   (fetched),
      .dout  (skid_word),
      .valid (skid_valid)
   );

   always_ff @(posedge iClk) begin
      if (!nRst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_VECTOR;
         target_q   <= 32'h0;
         out_q      <= '{pc: 32'h0, pc4: 32'h0, ins: NOP};
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         target_q   <= target_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      target_d   = target_q;
      out_d      = out_q;
      valid_d    = valid_q;
      skid_load  = 1'b0;
      skid_clear = 1'b0;

      if (bus.iEn) begin
         if (bus.iPCS_EXT) begin
            // Redirect beats stall and ack: bubble out, drop any held word.
            valid_d    = 1'b0;
            out_d.ins  = NOP;
            skid_clear = 1'b1;
            if (req && !bus.iIMemAck) begin
               // Access still in flight: keep requesting the old address and
               // remember where to go once its ack has been discarded.
               state_d  = S_DROP;
               target_d = word_align(bus.iPC_EXT);
            end else begin
               state_d    = S_FETCH;
               fetch_pc_d = word_align(bus.iPC_EXT);
            end
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  state_d = S_FETCH;
                  if (!bus.iStall) begin
                     valid_d   = 1'b0;
                     out_d.ins = NOP;
                  end
               end
               S_FETCH: begin
                  if (bus.iIMemAck) begin
                     fetch_pc_d = fetched.pc4;
                     if (bus.iStall) begin
                        skid_load = 1'b1;
                        state_d   = S_HOLD;
                     end else begin
                        out_d   = fetched;
                        valid_d = 1'b1;
                     end
                  end else if (!bus.iStall) begin
                     valid_d   = 1'b0;
                     out_d.ins = NOP;
                  end
               end
               S_HOLD: begin
                  if (!bus.iStall) begin
                     if (skid_valid) begin
                        out_d   = skid_word;
                        valid_d = 1'b1;
                     end else begin
                        valid_d   = 1'b0;
                        out_d.ins = NOP;
                     end
                     skid_clear = 1'b1;
                     state_d    = S_FETCH;
                  end
               end
               S_DROP: begin
                  if (!bus.iStall) begin
                     valid_d   = 1'b0;
                     out_d.ins = NOP;
                  end
                  if (bus.iIMemAck) begin
                     state_d    = S_FETCH;
                     fetch_pc_d = target_q;
                  end
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   assign bus.oIMemReq    = req;
   assign bus.oIMemAddr   = fetch_pc_q;
   assign bus.oPC         = out_q.pc;
   assign bus.oPC4        = out_q.pc4;
   assign bus.oINS        = out_q.ins;
   assign bus.oValid      = valid_q;
   assign bus.fetch_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage -- bench for fetch_stage: directed scenarios with literal
// expectations, a randomized phase against a behavioural model, and a second
// instance with a reset vector near the top of the address space.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
   import rv32_isa::*;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   // ---------------- clock / reset ----------------
   logic iClk = 1'b0;
   always #5 iClk = ~iClk;

   logic nRst   = 1'b0;
   logic nRst_w = 1'b0;

   fetch_stage_if bus ();
   fetch_stage_if bus_w ();

   fetch_stage u_dut (
      .iClk (iClk),
      .nRst (nRst),
      .bus  (bus)
   );

   fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut_w (
      .iClk (iClk),
      .nRst (nRst_w),
      .bus  (bus_w)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks what decode and memory must see: the next address to fetch, an
   // access whose data must be thrown away, a word parked because decode was
   // busy, and the instruction currently presented.
   typedef struct packed {
      logic        ready;
      logic        first;
      logic        hold;
      logic        discard;
      logic        valid;
      logic [31:0] addr;
      logic [31:0] target;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] ins;
      logic [31:0] held_pc;
      logic [31:0] held_ins;
   } model_t;

   model_t m = '0;

   function automatic model_t model_step(input model_t cur, input logic rst_n, input logic en,
                                         input logic stall, input logic redir,
                                         input logic [31:0] rtgt, input logic ack,
                                         input logic [31:0] data);
      model_t n;
      logic   outstanding;
      n = cur;
      if (!rst_n) begin
         n       = '0;
         n.ready = 1'b1;
         n.first = 1'b1;
         n.ins   = NOP_WORD;
         return n;
      end
      if (!en) return n;
      outstanding = !cur.first && !cur.hold;
      if (redir) begin
         n.valid = 1'b0;
         n.ins   = NOP_WORD;
         n.hold  = 1'b0;
         n.first = 1'b0;
         if (outstanding && !ack) begin
            n.discard = 1'b1;
            n.target  = {rtgt[31:2], 2'b00};
         end else begin
            n.discard = 1'b0;
            n.addr    = {rtgt[31:2], 2'b00};
         end
      end else if (cur.first) begin
         n.first = 1'b0;
         if (!stall) begin
            n.valid = 1'b0;
            n.ins   = NOP_WORD;
         end
      end else if (cur.hold) begin
         if (!stall) begin
            n.hold  = 1'b0;
            n.pc    = cur.held_pc;
            n.pc4   = cur.held_pc + 32'd4;
            n.ins   = cur.held_ins;
            n.valid = 1'b1;
         end
      end else if (cur.discard) begin
         if (!stall) begin
            n.valid = 1'b0;
            n.ins   = NOP_WORD;
         end
         if (ack) begin
            n.discard = 1'b0;
            n.addr    = cur.target;
         end
      end else if (ack) begin
         n.addr = cur.addr + 32'd4;
         if (stall) begin
            n.hold     = 1'b1;
            n.held_pc  = cur.addr;
            n.held_ins = data;
         end else begin
            n.pc    = cur.addr;
            n.pc4   = cur.addr + 32'd4;
            n.ins   = data;
            n.valid = 1'b1;
         end
      end else if (!stall) begin
         n.valid = 1'b0;
         n.ins   = NOP_WORD;
      end
      return n;
   endfunction

   always @(posedge iClk)
      m <= model_step(m, nRst, bus.iEn, bus.iStall, bus.iPCS_EXT, bus.iPC_EXT,
                      bus.iIMemAck, bus.iIMemData);

   // ---------------- compare process ----------------
   always @(negedge iClk) begin : compare
      fetch_state_e es;
      if (m.ready) begin
         es = m.first ? S_IDLE : (m.hold ? S_HOLD : (m.discard ? S_DROP : S_FETCH));
         check("oIMemReq", 32'(bus.oIMemReq), 32'(!m.first && !m.hold));
         check("oIMemAddr", bus.oIMemAddr, m.addr);
         check("oPC", bus.oPC, m.pc);
         check("oPC4", bus.oPC4, m.pc4);
         check("oINS", bus.oINS, m.ins);
         check("oValid", 32'(bus.oValid), 32'(m.valid));
         check("state", 32'(bus.fetch_state), 32'(es));
      end
   end

   // ---------------- memory responder / driver ----------------
   int mem_lat  = 0;
   bit mem_busy = 1'b0;
   int lat_lo   = 0;
   int lat_hi   = 0;

   task automatic mem_decide(input logic rst_n, input logic en,
                             output logic ack, output logic [31:0] data);
      ack  = 1'b0;
      data = $urandom;
      if (!rst_n) begin
         mem_busy = 1'b0;
      end else if (en && bus.oIMemReq === 1'b1) begin
         if (!mem_busy) begin
            mem_lat  = $urandom_range(lat_hi, lat_lo);
            mem_busy = 1'b1;
         end
         if (mem_lat == 0) begin
            ack      = 1'b1;
            data     = word_at(bus.oIMemAddr);
            mem_busy = 1'b0;
         end else begin
            mem_lat--;
         end
      end
   endtask

   task automatic tick(input logic rst_n, input logic en, input logic stall,
                       input logic redir, input logic [31:0] tgt);
      logic        ack;
      logic [31:0] data;
      mem_decide(rst_n, en, ack, data);
      nRst          = rst_n;
      bus.iEn       = en;
      bus.iStall    = stall;
      bus.iPCS_EXT  = redir;
      bus.iPC_EXT   = tgt;
      bus.iIMemAck  = ack;
      bus.iIMemData = data;
      @(posedge iClk);
      #1;
   endtask

   task automatic tick_w(input logic rst_n, input logic ack);
      nRst_w          = rst_n;
      bus_w.iEn       = 1'b1;
      bus_w.iStall    = 1'b0;
      bus_w.iPCS_EXT  = 1'b0;
      bus_w.iPC_EXT   = 32'h0;
      bus_w.iIMemAck  = ack;
      bus_w.iIMemData = word_at(bus_w.oIMemAddr);
      @(posedge iClk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] pc,
                             input logic [31:0] ins, input logic valid);
      check({tag, ".oPC"}, bus.oPC, pc);
      check({tag, ".oPC4"}, bus.oPC4, pc + 32'd4);
      check({tag, ".oINS"}, bus.oINS, ins);
      check({tag, ".oValid"}, 32'(bus.oValid), 32'(valid));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic        r_rst, r_en, r_stall, r_redir;
      logic [31:0] r_tgt;

      bus_w.iEn       = 1'b1;
      bus_w.iStall    = 1'b0;
      bus_w.iPCS_EXT  = 1'b0;
      bus_w.iPC_EXT   = 32'h0;
      bus_w.iIMemAck  = 1'b0;
      bus_w.iIMemData = 32'h0;

      // Reset values
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("rst.oIMemReq", 32'(bus.oIMemReq), 32'd0);
      check("rst.oIMemAddr", bus.oIMemAddr, 32'h0);
      check("rst.oPC", bus.oPC, 32'h0);
      check("rst.oPC4", bus.oPC4, 32'h0);
      check("rst.oINS", bus.oINS, NOP_WORD);
      check("rst.oValid", 32'(bus.oValid), 32'd0);

      // Single-cycle memory, no stall: sequential stream
      lat_lo = 0;
      lat_hi = 0;
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("seq.req1", 32'(bus.oIMemReq), 32'd1);
      check("seq.addr0", bus.oIMemAddr, 32'h0);
      check("seq.noval", 32'(bus.oValid), 32'd0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_out("seq0", 32'h0, word_at(32'h0), 1'b1);
      check("seq.addr4", bus.oIMemAddr, 32'h4);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_out("seq4", 32'h4, word_at(32'h4), 1'b1);
      check("seq.addr8", bus.oIMemAddr, 32'h8);

      // Stall for three cycles while the word at 8 arrives
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         expect_out("stall", 32'h4, word_at(32'h4), 1'b1);
         check("stall.req", 32'(bus.oIMemReq), 32'd0);
         check("stall.state", 32'(bus.fetch_state), 32'(S_HOLD));
      end
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_out("release", 32'h8, word_at(32'h8), 1'b1);
      check("release.req", 32'(bus.oIMemReq), 32'd1);
      check("release.addr", bus.oIMemAddr, 32'hC);

      // Redirect while a two-cycle-latency access is in flight
      lat_lo = 2;
      lat_hi = 2;
      tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
      expect_out("drop0", 32'h8, NOP_WORD, 1'b0);
      check("drop0.addr", bus.oIMemAddr, 32'hC);
      check("drop0.state", 32'(bus.fetch_state), 32'(S_DROP));
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("drop1.valid", 32'(bus.oValid), 32'd0);
      check("drop1.addr", bus.oIMemAddr, 32'hC);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("drop2.valid", 32'(bus.oValid), 32'd0);
      check("drop2.addr", bus.oIMemAddr, 32'h100);
      lat_lo = 0;
      lat_hi = 0;
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_out("tgt", 32'h100, word_at(32'h100), 1'b1);

      // Redirect coincident with an ack while stalled
      tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      expect_out("redack", 32'h100, NOP_WORD, 1'b0);
      check("redack.state", 32'(bus.fetch_state), 32'(S_FETCH));
      check("redack.addr", bus.oIMemAddr, 32'h200);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expect_out("redack2", 32'h200, word_at(32'h200), 1'b1);

      // Reset while holding a skid entry
      tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check("hold.state", 32'(bus.fetch_state), 32'(S_HOLD));
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("hrst.oIMemReq", 32'(bus.oIMemReq), 32'd0);
      check("hrst.oIMemAddr", bus.oIMemAddr, 32'h0);
      check("hrst.oPC", bus.oPC, 32'h0);
      check("hrst.oPC4", bus.oPC4, 32'h0);
      check("hrst.oINS", bus.oINS, NOP_WORD);
      check("hrst.oValid", 32'(bus.oValid), 32'd0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("hrst.req1", 32'(bus.oIMemReq), 32'd1);
      check("hrst.addr", bus.oIMemAddr, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) begin
            lat_lo = 0;
            lat_hi = $urandom_range(3, 0);
         end
         r_rst   = ($urandom_range(299, 0) != 0);
         r_en    = ($urandom_range(9, 0) != 0);
         r_stall = ($urandom_range(3, 0) == 0);
         r_redir = r_en && ($urandom_range(19, 0) == 0);
         r_tgt   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                              : 32'($urandom);
         tick(r_rst, r_en, r_stall, r_redir, r_tgt);
      end

      // Wrapping reset vector on the second instance; first instance frozen
      tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      tick_w(1'b0, 1'b0);
      tick_w(1'b0, 1'b0);
      check("wrap.rstaddr", bus_w.oIMemAddr, 32'hFFFF_FFF8);
      tick_w(1'b1, 1'b0);
      check("wrap.req", 32'(bus_w.oIMemReq), 32'd1);
      check("wrap.addr0", bus_w.oIMemAddr, 32'hFFFF_FFF8);
      tick_w(1'b1, bus_w.oIMemReq);
      check("wrap.pc0", bus_w.oPC, 32'hFFFF_FFF8);
      check("wrap.addr1", bus_w.oIMemAddr, 32'hFFFF_FFFC);
      tick_w(1'b1, bus_w.oIMemReq);
      check("wrap.pc1", bus_w.oPC, 32'hFFFF_FFFC);
      check("wrap.pc4_1", bus_w.oPC4, 32'h0000_0000);
      check("wrap.ins1", bus_w.oINS, word_at(32'hFFFF_FFFC));
      check("wrap.addr2", bus_w.oIMemAddr, 32'h0000_0000);
      tick_w(1'b1, bus_w.oIMemReq);
      check("wrap.pc2", bus_w.oPC, 32'h0000_0000);
      check("wrap.pc4_2", bus_w.oPC4, 32'h0000_0004);
      check("wrap.valid", 32'(bus_w.oValid), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
